// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK transmit modulator: FSM state encoding,
// carrier period, carrier sine table and the default sync word.
package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        DATA
    } state_t;

    localparam int unsigned CARRIER_PERIOD = 8;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hD5;

    // One carrier period at 8 samples per cycle, bounded to +/-127 so that
    // negation never overflows an 8-bit signed value.
    localparam logic signed [7:0] CARRIER_LUT [CARRIER_PERIOD] = '{
        8'sd0, 8'sd90, 8'sd127, 8'sd90, 8'sd0, -8'sd90, -8'sd127, -8'sd90
    };

endpackage

// File: rtl/bpsk_carrier_lut.sv
// Combinational carrier sample lookup: phase index plus polarity gives the
// signed 8-bit modulated sample. The caller registers the result.
module bpsk_carrier_lut
    import bpsk_pkg::*;
(
    input  logic [2:0]        phase,
    input  logic              negate,
    output logic signed [7:0] sample
);

    // Select the table entry and flip its sign for negative polarity
    always_comb begin
        sample = negate ? -CARRIER_LUT[phase] : CARRIER_LUT[phase];
    end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK transmit modulator: accepts bytes over valid/ready, frames them with
// an alternating preamble and a sync word, and emits a phase-modulated sine
// carrier at 8 samples per carrier cycle. Bytes offered on the final sample
// of the current byte continue the same frame without a gap.
// Optional feature macro: BPSK_DIFF_ENCODE_EN (differential encoding).
module bpsk_modulator
    import bpsk_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_BIT = 16,
    parameter int unsigned PREAMBLE_BITS   = 16,
    parameter logic [7:0]  SYNC_WORD       = DEFAULT_SYNC_WORD
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic signed [7:0] signal,
    output logic              busy,
    output logic              bit_strobe
);

    localparam int unsigned SW      = $clog2(SAMPLES_PER_BIT);
    localparam int unsigned BIT_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
    localparam int unsigned BW      = $clog2(BIT_MAX);

    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_BIT - 1);
    localparam logic [BW-1:0] PRE_LAST  = BW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(7);

    state_t          state, state_n;
    logic [SW-1:0]   samp_cnt, samp_n;
    logic [BW-1:0]   bit_cnt, bit_n_cnt;
    logic [2:0]      phase, phase_n;
    logic [7:0]      byte_reg, byte_n;
    logic            accept;
    logic            new_bit;
    logic            bit_val;
    logic            neg_n;
    logic [2:0]      msb_idx;
    logic signed [7:0] lut_sample;

`ifdef BPSK_DIFF_ENCODE_EN
    logic            neg;
`endif

    // Next-state, counter and byte-register update for the following sample
    always_comb begin
        state_n   = state;
        samp_n    = samp_cnt;
        bit_n_cnt = bit_cnt;
        phase_n   = phase;
        byte_n    = byte_reg;
        accept    = data_valid & data_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = PREAMBLE;
                    byte_n    = data_in;
                    samp_n    = '0;
                    bit_n_cnt = '0;
                    phase_n   = '0;
                end
            end
            default: begin
                phase_n = phase + 3'd1;
                if (samp_cnt != SAMP_LAST) begin
                    samp_n = samp_cnt + SW'(1);
                end else begin
                    samp_n = '0;
                    if (bit_cnt != ((state == PREAMBLE) ? PRE_LAST : BYTE_LAST)) begin
                        bit_n_cnt = bit_cnt + BW'(1);
                    end else begin
                        bit_n_cnt = '0;
                        case (state)
                            PREAMBLE: state_n = SYNC;
                            SYNC:     state_n = DATA;
                            DATA: begin
                                if (accept) begin
                                    byte_n = data_in;
                                end else begin
                                    state_n = IDLE;
                                    phase_n = '0;
                                end
                            end
                            default:  state_n = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Value of the bit the next sample belongs to, and its carrier polarity
    always_comb begin
        msb_idx = 3'd7 - bit_n_cnt[2:0];
        new_bit = (state_n != IDLE) && (samp_n == '0);
        case (state_n)
            PREAMBLE: bit_val = ~bit_n_cnt[0];
            SYNC:     bit_val = SYNC_WORD[msb_idx];
            DATA:     bit_val = byte_n[msb_idx];
            default:  bit_val = 1'b1;
        endcase
`ifdef BPSK_DIFF_ENCODE_EN
        // Polarity restarts positive at frame start and flips before each 1 bit
        if (state_n == IDLE) begin
            neg_n = 1'b0;
        end else if (new_bit) begin
            neg_n = ((state == IDLE) ? 1'b0 : neg) ^ bit_val;
        end else begin
            neg_n = neg;
        end
`else
        neg_n = ~bit_val;
`endif
    end

    bpsk_carrier_lut u_lut (
        .phase  (phase_n),
        .negate (neg_n),
        .sample (lut_sample)
    );

    // FSM state, counters and all outputs registered together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            phase      <= '0;
            byte_reg   <= '0;
            signal     <= '0;
            busy       <= 1'b0;
            bit_strobe <= 1'b0;
            data_ready <= 1'b1;
`ifdef BPSK_DIFF_ENCODE_EN
            neg        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            samp_cnt   <= samp_n;
            bit_cnt    <= bit_n_cnt;
            phase      <= phase_n;
            byte_reg   <= byte_n;
            signal     <= (state_n == IDLE) ? '0 : lut_sample;
            busy       <= (state_n != IDLE);
            bit_strobe <= new_bit;
            data_ready <= (state_n == IDLE) ||
                          ((state_n == DATA) && (bit_n_cnt == BYTE_LAST) && (samp_n == SAMP_LAST));
`ifdef BPSK_DIFF_ENCODE_EN
            neg        <= neg_n;
`endif
        end
    end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Self-checking bench for bpsk_modulator: randomized frames compared against
// a bit-list / sample-index reference model of the transmitted waveform.
module tb_bpsk_modulator;

    localparam int SPB  = 16;
    localparam int PB   = 16;
    localparam logic [7:0] SYNC = 8'hD5;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              data_valid = 1'b0;
    logic [7:0]        data_in = 8'h00;
    logic              data_ready;
    logic signed [7:0] signal;
    logic              busy;
    logic              bit_strobe;

    always #5 clock = ~clock;

    bpsk_modulator #(
        .SAMPLES_PER_BIT (SPB),
        .PREAMBLE_BITS   (PB),
        .SYNC_WORD       (SYNC)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .signal     (signal),
        .busy       (busy),
        .bit_strobe (bit_strobe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int cap_sig[$];
    bit cap_busy[$];
    bit cap_strb[$];
    bit cap_rdy[$];

    int exp_sig[$];
    bit exp_busy[$];
    bit exp_strb[$];
    bit exp_rdy[$];

    int lut_ref [8] = '{0, 90, 127, 90, 0, -90, -127, -90};

    // Reference waveform: list of frame bits, then sample k = sign(bit k/SPB) * sine[k mod 8]
    task automatic build_model(input logic [7:0] bytes[$]);
        bit bits[$];
        bit neg;
        int k;
        exp_sig.delete(); exp_busy.delete(); exp_strb.delete(); exp_rdy.delete();
        for (int i = 0; i < PB; i++) bits.push_back(i % 2 == 0);
        for (int i = 7; i >= 0; i--) bits.push_back(SYNC[i]);
        foreach (bytes[j]) begin
            logic [7:0] by;
            by = bytes[j];
            for (int i = 7; i >= 0; i--) bits.push_back(by[i]);
        end
        neg = 1'b0;
        for (int b = 0; b < bits.size(); b++) begin
`ifdef BPSK_DIFF_ENCODE_EN
            neg = neg ^ bits[b];
`else
            neg = !bits[b];
`endif
            for (int s = 0; s < SPB; s++) begin
                k = b * SPB + s;
                exp_sig.push_back(neg ? -lut_ref[k % 8] : lut_ref[k % 8]);
                exp_busy.push_back(1'b1);
                exp_strb.push_back(s == 0);
                exp_rdy.push_back((s == SPB - 1) && (b >= PB + 8) && (((b - PB - 8) % 8) == 7));
            end
        end
        exp_sig.push_back(0);
        exp_busy.push_back(1'b0);
        exp_strb.push_back(1'b0);
        exp_rdy.push_back(1'b1);
    endtask

    // Offer bytes (data_valid held until each is taken) and record one frame
    task automatic send_frame(input logic [7:0] bytes[$], output bit ok);
        int  idx;
        bit  started;
        bit  acc;
        cap_sig.delete(); cap_busy.delete(); cap_strb.delete(); cap_rdy.delete();
        idx = 0;
        started = 0;
        ok = 0;
        @(negedge clock);
        data_in = bytes[0];
        data_valid = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (started) begin
                cap_sig.push_back(int'(signal));
                cap_busy.push_back(busy);
                cap_strb.push_back(bit_strobe);
                cap_rdy.push_back(data_ready);
                if (!busy) begin
                    ok = 1;
                    break;
                end
            end
            acc = data_ready && data_valid;
            @(posedge clock);
            #1;
            if (acc) begin
                started = 1;
                idx++;
                if (idx < bytes.size()) data_in = bytes[idx];
                else begin
                    data_valid = 1'b0;
                    data_in = 8'($urandom);
                end
            end
            @(negedge clock);
        end
        data_valid = 1'b0;
    endtask

    function automatic int first_diff();
        int n;
        n = (cap_sig.size() < exp_sig.size()) ? cap_sig.size() : exp_sig.size();
        for (int i = 0; i < n; i++) begin
            if (cap_sig[i] != exp_sig[i] || cap_busy[i] != exp_busy[i] ||
                cap_strb[i] != exp_strb[i] || cap_rdy[i] != exp_rdy[i]) return i;
        end
        if (cap_sig.size() != exp_sig.size()) return n;
        return -1;
    endfunction

    function automatic int busy_count();
        int c = 0;
        foreach (cap_busy[i]) if (cap_busy[i]) c++;
        return c;
    endfunction

    task automatic test_reset();
        @(negedge clock);
        data_valid = 1'b1;
        data_in = 8'h3C;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (signal !== 8'sd0) begin n_fail++; $display("FAIL reset_signal: got %0d want 0", signal); end
        n_tests++;
        if (data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", data_ready); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++;
        if (bit_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", bit_strobe); end
        data_valid = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b ready=%b want busy=0 ready=1", busy, data_ready);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] q[$];
        bit ok;
        int d;
        int first8 [8] = '{0, 90, 127, 90, 0, -90, -127, -90};
        bit pol_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        q.push_back(8'hA5);
        build_model(q);
        send_frame(q, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL a5_timeout: frame end not seen, got %0d samples", cap_sig.size()); end
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL a5_stream: sample %0d got sig=%0d busy=%b strb=%b rdy=%b want sig=%0d busy=%b strb=%b rdy=%b",
                     d, (d < cap_sig.size()) ? cap_sig[d] : 999, (d < cap_busy.size()) ? cap_busy[d] : 1'b0,
                     (d < cap_strb.size()) ? cap_strb[d] : 1'b0, (d < cap_rdy.size()) ? cap_rdy[d] : 1'b0,
                     (d < exp_sig.size()) ? exp_sig[d] : 999, (d < exp_busy.size()) ? exp_busy[d] : 1'b0,
                     (d < exp_strb.size()) ? exp_strb[d] : 1'b0, (d < exp_rdy.size()) ? exp_rdy[d] : 1'b0);
        end
        n_tests++;
        if (busy_count() != 512) begin n_fail++; $display("FAIL a5_busy_len: got %0d want 512", busy_count()); end
`ifndef BPSK_DIFF_ENCODE_EN
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (cap_sig.size() <= i || cap_sig[i] != first8[i]) begin
                n_fail++;
                $display("FAIL a5_first8[%0d]: got %0d want %0d", i, (cap_sig.size() > i) ? cap_sig[i] : 999, first8[i]);
            end
        end
        for (int b = 0; b < 8; b++) begin
            int k = (24 + b) * SPB + 2;
            n_tests++;
            if (cap_sig.size() <= k || cap_sig[k] != (pol_a5[b] ? 127 : -127)) begin
                n_fail++;
                $display("FAIL a5_data_pol[%0d]: got %0d want %0d", 24 + b,
                         (cap_sig.size() > k) ? cap_sig[k] : 999, pol_a5[b] ? 127 : -127);
            end
        end
`endif
    endtask

    task automatic test_sync();
        logic [7:0] q[$];
        bit ok;
        int bad;
        bit pol_sync [8] = '{1, 1, 0, 1, 0, 1, 0, 1};
        q.push_back(8'($urandom));
        build_model(q);
        send_frame(q, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL sync_timeout: frame end not seen, got %0d samples", cap_sig.size()); end
`ifndef BPSK_DIFF_ENCODE_EN
        for (int b = 0; b < 8; b++) begin
            int k = (16 + b) * SPB + 2;
            n_tests++;
            if (cap_sig.size() <= k || cap_sig[k] != (pol_sync[b] ? 127 : -127)) begin
                n_fail++;
                $display("FAIL sync_pol[%0d]: got %0d want %0d", 16 + b,
                         (cap_sig.size() > k) ? cap_sig[k] : 999, pol_sync[b] ? 127 : -127);
            end
        end
`endif
        bad = -1;
        for (int k = 0; k < cap_strb.size() - 1; k++)
            if (cap_strb[k] != (k % SPB == 0)) begin bad = k; break; end
        n_tests++;
        if (bad != -1 || cap_strb.size() != 513) begin
            n_fail++;
            $display("FAIL sync_strobe: first bad sample %0d of %0d, want strobe every %0d over 513", bad, cap_strb.size(), SPB);
        end
        d_check_stream("sync_stream");
    endtask

    task automatic d_check_stream(input string name);
        int d;
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL %s: sample %0d got sig=%0d want sig=%0d (captured %0d, expected %0d samples)", name, d,
                     (d < cap_sig.size()) ? cap_sig[d] : 999, (d < exp_sig.size()) ? exp_sig[d] : 999,
                     cap_sig.size(), exp_sig.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        bit ok;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        build_model(q);
        send_frame(q, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout: frame end not seen, got %0d samples", cap_sig.size()); end
        n_tests++;
        if (busy_count() != 640) begin n_fail++; $display("FAIL b2b_busy_len: got %0d want 640", busy_count()); end
        n_tests++;
        if (cap_rdy.size() <= 511 || cap_rdy[511] !== 1'b1 || cap_rdy[510] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_511: got rdy510=%b rdy511=%b want 0,1",
                     (cap_rdy.size() > 510) ? cap_rdy[510] : 1'b0, (cap_rdy.size() > 511) ? cap_rdy[511] : 1'b0);
        end
`ifndef BPSK_DIFF_ENCODE_EN
        for (int b = 32; b < 40; b++) begin
            int k = b * SPB + 2;
            n_tests++;
            if (cap_sig.size() <= k || cap_sig[k] != 127) begin
                n_fail++;
                $display("FAIL b2b_pol[%0d]: got %0d want 127", b, (cap_sig.size() > k) ? cap_sig[k] : 999);
            end
        end
`endif
        d_check_stream("b2b_stream");
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            logic [7:0] q[$];
            bit ok;
            int n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge clock);
            build_model(q);
            send_frame(q, ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL rand_timeout[%0d]: frame end not seen", f); end
            d_check_stream($sformatf("rand_stream[%0d]", f));
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] q[$];
        bit ok;
        @(negedge clock);
        data_in = 8'($urandom);
        data_valid = 1'b1;
        @(posedge clock);
        #1 data_valid = 1'b0;
        repeat (100) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (signal !== 8'sd0 || busy !== 1'b0 || data_ready !== 1'b1 || bit_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got sig=%0d busy=%b rdy=%b strb=%b want 0,0,1,0", signal, busy, data_ready, bit_strobe);
        end
        @(negedge clock);
        reset_n = 1'b1;
        q.push_back(8'($urandom));
        build_model(q);
        send_frame(q, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL midreset_timeout: frame end not seen"); end
        d_check_stream("midreset_restart_stream");
    endtask

`ifdef BPSK_DIFF_ENCODE_EN
    task automatic test_diff();
        logic [7:0] q[$];
        bit ok;
        q.push_back(8'hFF);
        build_model(q);
        send_frame(q, ok);
        d_check_stream("diff_ff_stream");
        for (int b = 25; b < 32; b++) begin
            int k = b * SPB + 2;
            n_tests++;
            if (cap_sig.size() <= k || cap_sig[k] != -cap_sig[k - SPB] || cap_sig[k] == 0) begin
                n_fail++;
                $display("FAIL diff_ff_toggle[%0d]: got %0d want %0d", b,
                         (cap_sig.size() > k) ? cap_sig[k] : 999, (cap_sig.size() > k) ? -cap_sig[k - SPB] : 999);
            end
        end
        q.delete();
        q.push_back(8'h00);
        build_model(q);
        send_frame(q, ok);
        d_check_stream("diff_00_stream");
        for (int b = 25; b < 32; b++) begin
            int k = b * SPB + 2;
            n_tests++;
            if (cap_sig.size() <= k || cap_sig[k] != cap_sig[24 * SPB + 2] || cap_sig[k] == 0) begin
                n_fail++;
                $display("FAIL diff_00_hold[%0d]: got %0d want %0d", b,
                         (cap_sig.size() > k) ? cap_sig[k] : 999, (cap_sig.size() > 24 * SPB + 2) ? cap_sig[24 * SPB + 2] : 999);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_sync();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef BPSK_DIFF_ENCODE_EN
        test_diff();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bpsk_modulator.md
# bpsk_modulator

Transmit-side BPSK modulator: the stage upstream of the receiver's demodulator, producing the signed 8-bit sample stream the receiver consumes. Accepts bytes over a valid/ready handshake, frames them with a preamble and sync word, and emits a phase-modulated 8-sample-per-cycle sine carrier. Bytes offered back-to-back are sent in one continuous frame.

## Interface
- SAMPLES_PER_BIT, 16, samples per symbol; must be a nonzero multiple of CARRIER_PERIOD (8)
- PREAMBLE_BITS, 16, length of alternating 1010… preamble, ≥ 1
- SYNC_WORD, 8'hD5, sync byte sent MSB first after preamble

- clock  in  1  system/sample clock, one output sample per cycle
- reset_n  in  1  asynchronous, active-low reset
- data_in  in  8  payload byte
- data_valid  in  1  data_in valid
- data_ready  out  1  block accepts data_in this cycle when data_valid also high
- signal  out  signed 8  modulated sample, registered
- busy  out  1  frame in progress (state ≠ IDLE)
- bit_strobe  out  1  one-cycle pulse coincident with first sample of each transmitted bit

## Operation
- States: IDLE → PREAMBLE → SYNC → DATA → (DATA | IDLE).
- IDLE: signal = 0, data_ready = 1, busy = 0. On data_valid & data_ready, latch data_in into byte register, enter PREAMBLE.
- PREAMBLE: PREAMBLE_BITS bits, first bit 1, alternating.
- SYNC: 8 bits of SYNC_WORD, MSB first.
- DATA: 8 bits of latched byte, MSB first.
- data_ready in DATA is high only on the last sample of bit 7. If accepted there: latch new byte, stay in DATA, next bit is its MSB (no preamble, no gap). Otherwise → IDLE.
- data_ready low in PREAMBLE, SYNC and all other DATA cycles; data_in/data_valid ignored then.
- Sample generation: 3-bit carrier phase index p, reset to 0 at frame start, increments every sample (wraps 7→0). Carrier LUT p=0..7: 0, 90, 127, 90, 0, −90, −127, −90. Polarity +: signal = LUT[p]; polarity −: signal = −LUT[p]. LUT bounded to ±127, so negation never overflows.
- Polarity (macro absent): bit 1 → +, bit 0 → −.
- Sample counter 0..SAMPLES_PER_BIT−1 per bit; bit counter per state; widths from $clog2.
- Reset (any time, including mid-frame): state IDLE, signal 0, data_ready 1, busy 0, bit_strobe 0, counters and byte register 0, polarity +.

## Timing
- Handshake accepted at edge t (IDLE): at t+1 busy = 1, bit_strobe = 1, signal = first preamble sample (LUT[0] = 0, polarity +).
- Frame of N bytes: busy high for SAMPLES_PER_BIT × (PREAMBLE_BITS + 8 + 8N) cycles; cycle after the last sample, signal = 0, busy = 0, data_ready = 1.
- Back-to-back acceptance on the final sample of a byte: next byte's first sample on the immediately following cycle; p continues without reset.
- bit_strobe aligned with the sample where sample counter = 0.
- Output latency from state to signal: zero additional cycles (signal registered together with state).

## Configuration
- BPSK_DIFF_ENCODE_EN defined: differential encoding; polarity register starts + at frame start and toggles before each bit whose value is 1; bit 0 keeps polarity. Matches a differential demodulator (no phase ambiguity).
- Undefined: absolute polarity as in Operation; polarity register absent.

## Structure
- Package bpsk_pkg: state enum (IDLE, PREAMBLE, SYNC, DATA), CARRIER_PERIOD = 8, carrier LUT constants, default SYNC_WORD.
- One sub-module: bpsk_carrier_lut (3-bit phase, polarity → signed 8-bit sample, combinational); the modulator registers its output.

## Test plan
- Reset asserted with data_valid high → signal 0, data_ready 1, busy 0, no acceptance; release → IDLE.
- Send 0xA5 (defaults) → samples 0..7 = 0,90,127,90,0,−90,−127,−90; busy exactly 512 cycles; bits 24..31 polarity +,−,+,−,−,+,−,+.
- Check sync region (bits 16..23) → polarity pattern +,+,−,+,−,+,−,+ for 0xD5; bit_strobe every 16 cycles.
- 0x00 then 0xFF with data_valid held → second accepted on sample 511; no gap; busy 640 cycles; bits 32..39 all +.
- reset_n pulsed low at frame cycle 100 → signal 0 asynchronously, busy 0; next byte restarts full preamble.
- BPSK_DIFF_ENCODE_EN, send 0xFF → data bits alternate polarity each bit; 0x00 → polarity constant across all 8 data bits.
